// File: rtl/dram_responder.sv
// Purpose : data-RAM target for the MEM-stage dram_* port; 32-bit words, byte-lane writes.
// Latency : LATENCY cycles from request to commit (1 = plain synchronous BRAM, full rate).
// Backpr. : stallreq holds the pipeline while an access is in flight; drops in DONE or on abort.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   dram_en             access request, held stable while stallreq=1
//   dram_wen[3:0]       byte-lane write enables (0 = read)
//   dram_addr[31:0]     byte address; word index = dram_addr[ADDR_W+1:2]
//   dram_wdata[31:0]    lane-aligned store data
//   dram_rdata[31:0]    registered read word, held until the next read commit
//   stallreq            pipeline hold request
module dram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dram_en,
  input  logic [3:0]  dram_wen,
  input  logic [31:0] dram_addr,
  input  logic [31:0] dram_wdata,
  output logic [31:0] dram_rdata,
  output logic        stallreq
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] idx;
  logic              commit;
  logic              unused_addr_bits;

  // Byte offset and high bits are dropped: addresses alias, no fault is raised.
  assign idx              = dram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{dram_addr[31:ADDR_W+2], dram_addr[1:0]};

  if (LATENCY == 1) begin : g_direct
    // Every enabled cycle commits on its own edge; nothing to wait for.
    assign commit   = dram_en;
    assign stallreq = 1'b0;
  end else begin : g_fsm
    // Commit on the last WAIT edge using the live (held) inputs. Dropping
    // dram_en in WAIT is an abort: no commit and the stall releases at once.
    assign commit   = (state == WAIT) && dram_en && (cnt == 4'd1);
    assign stallreq = dram_en && ((state == IDLE) || (state == WAIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dram_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dram_en && (LATENCY > 1)) begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!dram_en) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= DONE;
          end
        end
        // DONE lets the pipeline advance; a request is not sampled here,
        // which enforces LATENCY+1 spacing between accesses.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit && (dram_wen == 4'b0000)) dram_rdata <= mem[idx];
    end
  end

  // Storage is never cleared; reset only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (dram_wen[i]) mem[idx][8*i +: 8] <= dram_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// Purpose : directed bench for dram_responder at LATENCY 1, 3 and 4.
// Latency : n/a (testbench).
// Backpr. : n/a (testbench).
module tb_dram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [2:0]        en_v;
  logic [2:0][3:0]   wen_v;
  logic [2:0][31:0]  addr_v;
  logic [2:0][31:0]  wd_v;
  logic [31:0]       rd0, rd1, rd2;
  logic              st0, st1, st2;

  int n_tests = 0;
  int n_fail  = 0;

  dram_responder #(.ADDR_W(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .dram_en(en_v[0]), .dram_wen(wen_v[0]),
    .dram_addr(addr_v[0]), .dram_wdata(wd_v[0]), .dram_rdata(rd0), .stallreq(st0)
  );
  dram_responder #(.ADDR_W(10), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .dram_en(en_v[1]), .dram_wen(wen_v[1]),
    .dram_addr(addr_v[1]), .dram_wdata(wd_v[1]), .dram_rdata(rd1), .stallreq(st1)
  );
  dram_responder #(.ADDR_W(10), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .dram_en(en_v[2]), .dram_wen(wen_v[2]),
    .dram_addr(addr_v[2]), .dram_wdata(wd_v[2]), .dram_rdata(rd2), .stallreq(st2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input int k);
    case (k)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  function automatic logic st_of(input int k);
    case (k)
      0:       return st0;
      1:       return st1;
      default: return st2;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LATENCY=1 access: one cycle, never stalls. Leaves dram_en asserted.
  task automatic acc1(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en_v[0] = 1'b1; wen_v[0] = w; addr_v[0] = a; wd_v[0] = d;
    #1 check("l1_no_stall", 32'(st0), 32'd1 - 32'd1);
    tick();
  endtask

  // Multi-cycle access: stall for lat cycles with rdata held, then DONE with stall low.
  task automatic run(input int k, input int lat, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] prev);
    en_v[k] = 1'b1; wen_v[k] = w; addr_v[k] = a; wd_v[k] = d;
    for (int i = 0; i < lat; i++) begin
      #1;
      check("busy_stall", 32'(st_of(k)), 32'd1);
      check("busy_rdata_hold", rd_of(k), prev);
      tick();
    end
    #1 check("done_stall", 32'(st_of(k)), 32'd0);
    en_v[k] = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en_v = '0; wen_v = '0; addr_v = '0; wd_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata_l1", rd0, 32'h0);
    check("rst_rdata_l3", rd1, 32'h0);
    check("rst_rdata_l4", rd2, 32'h0);
    check("rst_stall_l3", 32'(st1), 32'h0);
    check("rst_stall_l4", 32'(st2), 32'h0);
    rst = 1'b0;
    tick();

    // LATENCY=1: store then load back-to-back
    acc1(4'hF, 32'h100, 32'h11223344);
    check("l1_sw_keeps_rdata", rd0, 32'h0);
    acc1(4'h0, 32'h100, 32'h0);
    check("l1_lw_after_sw", rd0, 32'h11223344);

    // byte lanes
    acc1(4'hF, 32'h20, 32'h0);
    acc1(4'b0100, 32'h22, 32'hAAAAAAAA);
    acc1(4'h0, 32'h20, 32'h0);
    check("sb_lane2", rd0, 32'h00AA0000);
    acc1(4'b0001, 32'h20, 32'hAAAAAAAA);
    acc1(4'b1110, 32'h20, 32'h33221100);
    acc1(4'h0, 32'h20, 32'h0);
    check("swr_lanes3to1", rd0, 32'h332211AA);
    en_v[0] = 1'b0;
    tick(); tick();
    check("l1_rdata_held_idle", rd0, 32'h332211AA);

    // alias / unaligned
    acc1(4'hF, 32'h0000, 32'h5A5A5A5A);
    check("l1_rdata_held_over_sw", rd0, 32'h332211AA);
    acc1(4'h0, 32'h1003, 32'h0);
    check("alias_unaligned", rd0, 32'h5A5A5A5A);
    en_v[0] = 1'b0;
    tick();

    // LATENCY=3 write, read, then rdata held across a later write
    run(1, 3, 4'hF, 32'h40, 32'hCAFEF00D, 32'h0);
    run(1, 3, 4'h0, 32'h40, 32'h0, 32'h0);
    check("l3_read", rd1, 32'hCAFEF00D);
    run(1, 3, 4'hF, 32'h44, 32'h0BADF00D, 32'hCAFEF00D);
    check("l3_rdata_held", rd1, 32'hCAFEF00D);

    // LATENCY=4 abort in the second WAIT cycle
    run(2, 4, 4'hF, 32'h80, 32'h12345678, 32'h0);
    en_v[2] = 1'b1; wen_v[2] = 4'hF; addr_v[2] = 32'h80; wd_v[2] = 32'hDEADBEEF;
    #1 check("abort_idle_stall", 32'(st2), 32'd1);
    tick();
    #1 check("abort_wait1_stall", 32'(st2), 32'd1);
    tick();
    en_v[2] = 1'b0;
    #1 check("abort_stall_drop", 32'(st2), 32'd0);
    tick(); tick();
    run(2, 4, 4'h0, 32'h80, 32'h0, 32'h0);
    check("abort_no_write", rd2, 32'h12345678);

    // reset on what would be the commit edge of a pending write
    en_v[2] = 1'b1; wen_v[2] = 4'hF; addr_v[2] = 32'h80; wd_v[2] = 32'hFFFFFFFF;
    tick(); tick(); tick();
    #1 check("rst_pending_stall", 32'(st2), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en_v[2] = 1'b0;
    #1;
    check("rst_mid_rdata", rd2, 32'h0);
    check("rst_mid_stall", 32'(st2), 32'h0);
    check("rst_mid_rdata_l1", rd0, 32'h0);
    tick();
    run(2, 4, 4'h0, 32'h80, 32'h0, 32'h0);
    check("rst_mid_no_write", rd2, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
